// File: rtl/alu_pkg.sv
// Shared widths and ALU op encodings for the issue/execute slice.
package alu_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 1 << REG_AW;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_OR   = 3'd1,
    ALU_SRL  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_SUB  = 3'd4
  } alu_op_e;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    reg_onehot = '0;
    reg_onehot[r] = 1'b1;
  endfunction
endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two read ports with same-cycle writeback bypass, x0 hardwired to zero.
module reg_file
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);
  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0)                    rs1_data = '0;
    else if (we && waddr == rs1_addr)      rs1_data = wdata;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0)                    rs2_data = '0;
    else if (we && waddr == rs2_addr)      rs2_data = wdata;
  end
endmodule

// File: rtl/issue_stage.sv
// Issue stage: operand read, scoreboard hazard stall and a one-deep registered
// output toward execute with valid/ready handshake.
module issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_prog,
  input  logic              in_reg_write,
  input  logic              in_branch,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   srcA,
  output logic [XLEN-1:0]   srcB,
  output logic [2:0]        prog,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_branch
);
  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic [NREGS-1:0] busy, wb_clr, busy_live, busy_set;
  logic             hazard, accept;

  reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (in_rs1),
    .rs2_addr (in_rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_we),
    .waddr    (wb_addr),
    .wdata    (wb_data)
  );

  // A register being written back this cycle is already free for readers.
  always_comb begin
    wb_clr    = wb_we ? reg_onehot(wb_addr) : '0;
    busy_live = busy & ~wb_clr;
    hazard    = in_valid & (busy_live[in_rs1] | (busy_live[in_rs2] & ~in_use_imm));
    in_ready  = (~out_valid | out_ready) & ~hazard & ~flush;
    accept    = in_valid & in_ready;
    busy_set  = (accept && in_reg_write && in_rd != '0) ? reg_onehot(in_rd) : '0;
  end

  // Set is applied after clear so a same-cycle set/clear of one bit stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= busy_live | busy_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      srcA          <= '0;
      srcB          <= '0;
      prog          <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_branch    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      srcA          <= rs1_data;
      srcB          <= in_use_imm ? in_imm : rs2_data;
      prog          <= in_prog;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write;
      out_branch    <= in_branch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
